// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Purpose:
//   Round-robin arbiter/sequencer that shares one fixed-latency sequential
//   multiplier core among NUM_REQ requesters. One operand pair is accepted at
//   a time. The pair is issued to the core with a one-cycle start pulse. The
//   product is captured after CALC_CYCLES and returned to the granted
//   requester over a response channel.
//
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   req_valid     : per-requester operand valid          (NUM_REQ)
//   req_ready     : per-requester accept, at most one hot (NUM_REQ)
//   req_a, req_b  : packed operands, requester k at [k*WIDTH +: WIDTH]
//   resp_valid    : one-hot response valid               (NUM_REQ)
//   resp_ready    : per-requester response accept        (NUM_REQ)
//   resp_data     : captured product, shared by all      (2*WIDTH)
//   mult_start    : one-cycle start pulse to the core
//   mult_a/mult_b : operands to the core, held from ISSUE through RESP
//   mult_c        : result from the core                 (2*WIDTH)
//   busy          : high in every state except IDLE
//   grant_id      : index of the current or last granted requester
//   dbg_state     : current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Handshake semantics (both channels):
//   A transfer happens on a rising edge where valid and ready are both high.
//   Request side: req_ready is produced combinationally in IDLE for the
//   round-robin winner only. A req_valid that drops before its transfer
//   leaves no trace. Response side: resp_valid[grant_id] stays high with
//   resp_data frozen until resp_ready[grant_id] is seen high on an edge.
//   resp_ready bits of other requesters are ignored.
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 4,
  parameter int CALC_CYCLES = 10,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [2*WIDTH-1:0]         resp_data,
  output logic                       mult_start,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic [2*WIDTH-1:0]         mult_c,
  output logic                       busy,
  output logic [ID_W-1:0]            grant_id,
  output logic [1:0]                 dbg_state
);

  localparam int CNT_W = $clog2(CALC_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_grant;
  logic [WIDTH-1:0]    r_mult_a;
  logic [WIDTH-1:0]    r_mult_b;
  logic [2*WIDTH-1:0]  r_resp_data;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_found;
  logic [ID_W-1:0]     w_winner;
  logic [WIDTH-1:0]    w_sel_a;
  logic [WIDTH-1:0]    w_sel_b;
  logic                w_accept;
  logic                w_calc_done;
  logic                w_resp_done;
  logic [ID_W-1:0]     w_ptr_next;

  // Round-robin search: first valid requester at or above the pointer,
  // wrapping back to 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[(int'(r_ptr) + i) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = ID_W'((int'(r_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign w_sel_a     = req_a[int'(w_winner)*WIDTH +: WIDTH];
  assign w_sel_b     = req_b[int'(w_winner)*WIDTH +: WIDTH];
  assign w_accept    = (r_state == IDLE) && w_found;
  // r_cnt is 0 in the first WAIT cycle, so CALC_CYCLES-1 marks the last one.
  assign w_calc_done = (r_state == WAIT) && (r_cnt == CNT_W'(CALC_CYCLES - 1));
  assign w_resp_done = (r_state == RESP) && resp_ready[r_grant];
  assign w_ptr_next  = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + ID_W'(1);

  // Next-state and per-state outputs.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    resp_valid   = '0;
    mult_start   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_found) begin
          req_ready[w_winner] = 1'b1;
          w_next_state        = ISSUE;
        end
      end
      ISSUE: begin
        mult_start   = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: begin
        if (w_calc_done) w_next_state = RESP;
      end
      RESP: begin
        resp_valid[r_grant] = 1'b1;
        if (w_resp_done) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_mult_a    <= '0;
      r_mult_b    <= '0;
      r_resp_data <= '0;
      r_cnt       <= '0;
    end else begin
      // Operands are only loaded on an accept, so they stay put until the
      // block is back in IDLE.
      if (w_accept) begin
        r_mult_a <= w_sel_a;
        r_mult_b <= w_sel_b;
        r_grant  <= w_winner;
      end
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_calc_done) begin
        r_resp_data <= mult_c;
      end
      if (w_resp_done) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  assign mult_a    = r_mult_a;
  assign mult_b    = r_mult_b;
  assign resp_data = r_resp_data;
  assign grant_id  = r_grant;
  assign dbg_state = r_state;

endmodule
